// File: rtl/ch_unit_pkg.sv
// Shared channel-unit definitions: transmitter state encoding, bus levels and
// the 2-of-3 vote used by the transmitter and the ID comparator.
package ch_unit_pkg;

    localparam int DEFAULT_ID_LENGTH = 11;

    localparam logic RECESSIVE = 1'b1;
    localparam logic DOMINANT  = 1'b0;

    typedef enum logic [6:0] {
        S_IDLE   = 7'b0000001,
        S_SAMPLE = 7'b0000010,
        S_CHECK  = 7'b0000100,
        S_WAIT   = 7'b0001000,
        S_WON    = 7'b0010000,
        S_LOST   = 7'b0100000,
        S_ERROR  = 7'b1000000
    } txState_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sample_voter.sv
// Collects three bus samples per bit period and registers their majority.
// thirdPulse is high in the cycle the final sample of a bit is taken.
module sample_voter
    import ch_unit_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic sampleEn,
    input  logic dIn,
    output logic thirdPulse,
    output logic majority
);

    logic [1:0] sampleCount;
    logic [1:0] samples;

    assign thirdPulse = sampleEn && (sampleCount == 2'd2);

    // The third sample is voted directly from dIn, so only two slots are stored.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sampleCount <= 2'd0;
            samples     <= {2{RECESSIVE}};
            majority    <= RECESSIVE;
        end else if (sampleEn) begin
            if (thirdPulse) begin
                sampleCount <= 2'd0;
                majority    <= maj3(samples[0], samples[1], dIn);
            end else begin
                samples[sampleCount[0]] <= dIn;
                sampleCount             <= sampleCount + 2'd1;
            end
        end
    end

endmodule

// File: rtl/id_transmitter.sv
// Serializes an identifier MSB first onto the bus and arbitrates by reading
// each bit back through the majority-voted sampler.
module id_transmitter
    import ch_unit_pkg::*;
#(
    parameter int ID_LENGTH = DEFAULT_ID_LENGTH
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        enable,
    input  logic [31:0] id,
    input  logic        txPulse,
    input  logic        samplePulse,
    input  logic        dIn,
    output logic        dOut,
    output logic        idSendComplete,
    output logic        arbWon,
    output logic        arbLost,
    output logic        bitErr
);

    localparam int CNT_W = $clog2(ID_LENGTH + 1);

    txState_t             state, stateNext;
    logic [ID_LENGTH-1:0] shiftReg, shiftNext, shifted;
    logic [CNT_W-1:0]     bitCount, bitCountNext;
    logic                 sampleEn, thirdPulse, readBit;

    assign sampleEn = samplePulse && (state == S_SAMPLE);

    sample_voter uVoter (
        .clk       (clk),
        .resetN    (resetN),
        .sampleEn  (sampleEn),
        .dIn       (dIn),
        .thirdPulse(thirdPulse),
        .majority  (readBit)
    );

    // The bit on the bus is always the MSB of the shift register; refilling
    // with recessive keeps dOut at 1 whenever nothing is being sent.
    assign dOut = shiftReg[ID_LENGTH-1];

    generate
        if (ID_LENGTH > 1) begin : gShift
            assign shifted = {shiftReg[ID_LENGTH-2:0], RECESSIVE};
        end else begin : gShiftSingle
            assign shifted = RECESSIVE;
        end
    endgenerate

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= S_IDLE;
            shiftReg <= '1;
            bitCount <= '0;
        end else begin
            state    <= stateNext;
            shiftReg <= shiftNext;
            bitCount <= bitCountNext;
        end
    end

    always_comb begin
        stateNext    = state;
        shiftNext    = shiftReg;
        bitCountNext = bitCount;
        case (state)
            S_IDLE: begin
                if (enable && txPulse) begin
                    shiftNext = id[ID_LENGTH-1:0];
                    stateNext = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (thirdPulse) begin
                    stateNext = S_CHECK;
                end
            end
            S_CHECK: begin
                if (dOut == RECESSIVE && readBit == DOMINANT) begin
                    stateNext = S_LOST;
                    shiftNext = '1;
                end else if (dOut == DOMINANT && readBit == RECESSIVE) begin
                    stateNext = S_ERROR;
                    shiftNext = '1;
                end else if (bitCount == CNT_W'(ID_LENGTH - 1)) begin
                    stateNext = S_WON;
                    shiftNext = '1;
                end else begin
                    bitCountNext = bitCount + CNT_W'(1);
                    stateNext    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (txPulse) begin
                    shiftNext = shifted;
                    stateNext = S_SAMPLE;
                end
            end
            S_WON, S_LOST, S_ERROR: begin
                shiftNext = '1;
            end
            default: begin
                stateNext = S_IDLE;
                shiftNext = '1;
            end
        endcase
    end

    assign arbWon         = (state == S_WON);
    assign arbLost        = (state == S_LOST);
    assign bitErr         = (state == S_ERROR);
    assign idSendComplete = arbWon || arbLost || bitErr;

endmodule

// File: tb/tb_id_transmitter.sv
// Bench for id_transmitter: hand-derived frame vectors, reset/ignored-pulse
// sequences and randomized frames checked against a bit-level arbitration model.
module tb_id_transmitter;
    import ch_unit_pkg::*;

    localparam int L    = 11;
    localparam int NONE = 99;

    logic        clk;
    logic        resetN;
    logic        enable;
    logic [31:0] id;
    logic        txPulse;
    logic        samplePulse;
    logic        dIn;
    logic        dOut;
    logic        idSendComplete;
    logic        arbWon;
    logic        arbLost;
    logic        bitErr;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;

    id_transmitter #(.ID_LENGTH(L)) dut (
        .clk           (clk),
        .resetN        (resetN),
        .enable        (enable),
        .id            (id),
        .txPulse       (txPulse),
        .samplePulse   (samplePulse),
        .dIn           (dIn),
        .dOut          (dOut),
        .idSendComplete(idSendComplete),
        .arbWon        (arbWon),
        .arbLost       (arbLost),
        .bitErr        (bitErr)
    );

    assign flags = {idSendComplete, arbWon, arbLost, bitErr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] idv;
        int          fBit;
        logic [2:0]  fMask;
        logic        fVal;
        int          expOc;    // 0 won, 1 lost, 2 bit error
        int          expLast;  // transmitted bit index at which the frame ends
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Arbitration outcome from the bus rules: per bit, vote the three samples
    // and compare with the driven level.
    function automatic void model(input logic [31:0] idv, input int fBit, input logic [2:0] m,
                                  input logic v, output int oc, output int last);
        oc   = 0;
        last = L - 1;
        for (int k = 0; k < L; k++) begin
            logic drv;
            int   ones;
            logic rd;
            drv  = idv[L-1-k];
            ones = 0;
            for (int s = 0; s < 3; s++) begin
                if ((k == fBit && m[s]) ? v : drv) ones++;
            end
            rd = (ones >= 2);
            if (drv && !rd) begin oc = 1; last = k; return; end
            if (!drv && rd) begin oc = 2; last = k; return; end
        end
    endfunction

    task automatic runFrame(input string tag, input logic [31:0] idv, input int fBit,
                            input logic [2:0] fMask, input logic fVal, input int expOc,
                            input int expLast, input int abortAt, input bit strays,
                            output logic [L-1:0] seq);
        logic [3:0] expFlags;
        logic       drv;
        int         gap;
        seq      = '1;
        expFlags = (expOc == 0) ? 4'b1100 : (expOc == 1) ? 4'b1010 : 4'b1001;
        id       = idv;
        enable   = 1'b1;
        for (int k = 0; k < L; k++) begin
            drv     = idv[L-1-k];
            txPulse = 1'b1;
            if (strays && $urandom_range(0, 1) == 1) begin
                samplePulse = 1'b1;
                dIn         = 1'($urandom_range(0, 1));
            end
            cyc();
            txPulse     = 1'b0;
            samplePulse = 1'b0;
            dIn         = 1'b1;
            if (strays) enable = 1'($urandom_range(0, 1));
            seq[L-1-k] = dOut;
            check($sformatf("%s dOut bit%0d", tag, k), dOut, drv);
            for (int s = 0; s < 3; s++) begin
                gap = strays ? $urandom_range(0, 3) : 0;
                for (int g = 0; g < gap; g++) begin
                    txPulse = 1'($urandom_range(0, 1));
                    cyc();
                    txPulse = 1'b0;
                end
                if (k == abortAt && s == 1) return;
                samplePulse = 1'b1;
                dIn         = (k == fBit && fMask[s]) ? fVal : drv;
                if (strays && $urandom_range(0, 3) == 0) txPulse = 1'b1;
                cyc();
                samplePulse = 1'b0;
                txPulse     = 1'b0;
                dIn         = 1'b1;
            end
            check($sformatf("%s flags in check bit%0d", tag, k), flags, 4'b0000);
            cyc();
            if (k == expLast) begin
                check($sformatf("%s end flags", tag), flags, expFlags);
                check($sformatf("%s end dOut", tag), dOut, 1'b1);
                for (int t = 0; t < 2; t++) begin
                    txPulse     = 1'b1;
                    samplePulse = 1'b1;
                    dIn         = 1'b0;
                    cyc();
                    txPulse     = 1'b0;
                    samplePulse = 1'b0;
                    dIn         = 1'b1;
                    cyc();
                end
                check($sformatf("%s held flags", tag), flags, expFlags);
                check($sformatf("%s held dOut", tag), dOut, 1'b1);
                return;
            end
            check($sformatf("%s flags after bit%0d", tag, k), flags, 4'b0000);
            check($sformatf("%s dOut hold bit%0d", tag, k), dOut, drv);
            // Stray dominant samples in S_WAIT must not count toward the next bit.
            gap = strays ? $urandom_range(0, 3) : 0;
            for (int g = 0; g < gap; g++) begin
                samplePulse = 1'b1;
                dIn         = 1'b0;
                cyc();
                samplePulse = 1'b0;
                dIn         = 1'b1;
            end
        end
        check($sformatf("%s frame ran past end", tag), 32'd1, 32'd0);
    endtask

    task automatic doReset(input string tag);
        #2;
        resetN = 1'b0;
        #1;
        check($sformatf("%s async dOut", tag), dOut, 1'b1);
        check($sformatf("%s async flags", tag), flags, 4'b0000);
        @(negedge clk);
        resetN = 1'b1;
        cyc();
    endtask

    initial begin
        logic [L-1:0] seq;
        logic [31:0]  rid;
        int           rfBit, rOc, rLast;
        logic [2:0]   rMask;
        logic         rVal;

        resetN      = 1'b0;
        enable      = 1'b0;
        id          = '0;
        txPulse     = 1'b0;
        samplePulse = 1'b0;
        dIn         = 1'b1;

        vecs[0] = '{32'h5A3, NONE, 3'b000, 1'b0, 0, 10};
        vecs[1] = '{32'h7FF, 3,    3'b111, 1'b0, 1, 3};
        vecs[2] = '{32'h000, 0,    3'b111, 1'b1, 2, 0};
        vecs[3] = '{32'h7FF, 6,    3'b010, 1'b0, 0, 10};
        vecs[4] = '{32'h7FF, 6,    3'b011, 1'b0, 1, 6};
        vecs[5] = '{32'h000, 10,   3'b100, 1'b1, 0, 10};
        vecs[6] = '{32'h000, 10,   3'b101, 1'b1, 2, 10};
        vecs[7] = '{32'h2AA, 1,    3'b111, 1'b0, 1, 1};

        repeat (2) cyc();
        check("reset dOut", dOut, 1'b1);
        check("reset flags", flags, 4'b0000);
        resetN = 1'b1;
        cyc();

        for (int i = 0; i < 8; i++) begin
            runFrame($sformatf("vec%0d", i), vecs[i].idv, vecs[i].fBit, vecs[i].fMask,
                     vecs[i].fVal, vecs[i].expOc, vecs[i].expLast, NONE, 1'b0, seq);
            if (i == 0) check("vec0 dOut sequence", 32'(seq), 32'h5A3);
            doReset($sformatf("vec%0d reset", i));
        end

        // Reset during bit 5 of an all-dominant frame, then pulses with enable low.
        runFrame("midrst", 32'h000, NONE, 3'b000, 1'b0, 0, L - 1, 5, 1'b0, seq);
        check("midrst dOut before reset", dOut, 1'b0);
        doReset("midrst");
        enable = 1'b0;
        id     = 32'h000;
        for (int t = 0; t < 3; t++) begin
            txPulse = 1'b1;
            cyc();
            txPulse = 1'b0;
            cyc();
            check($sformatf("idle txPulse%0d dOut", t), dOut, 1'b1);
            check($sformatf("idle txPulse%0d flags", t), flags, 4'b0000);
        end
        runFrame("strays", 32'h7FF, NONE, 3'b000, 1'b0, 0, L - 1, NONE, 1'b1, seq);
        doReset("strays reset");

        for (int r = 0; r < 24; r++) begin
            rid   = $urandom & 32'h7FF;
            rfBit = $urandom_range(0, 14);
            rMask = 3'($urandom_range(0, 7));
            rVal  = 1'($urandom_range(0, 1));
            model(rid, rfBit, rMask, rVal, rOc, rLast);
            runFrame($sformatf("rnd%0d", r), rid, rfBit, rMask, rVal, rOc, rLast, NONE, 1'b1, seq);
            doReset($sformatf("rnd%0d reset", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_transmitter.md
# id_transmitter

Transmit-side counterpart of the channel unit's ID comparator: serializes an identifier onto the bus MSB first, one bit per bit period, and reads the bus back to arbitrate. Each bit is launched on a bit-start pulse and read back through three sample pulses, which are majority-voted. A recessive-driven bit read back dominant loses arbitration. A dominant-driven bit read back recessive is a bit error. Sits beside the comparator in the channel unit and shares its sample-pulse timing source.

## Interface
- ID_LENGTH, 11: number of ID bits transmitted (1-32)
- clk  in  1  system clock, all logic on rising edge
- resetN  in  1  asynchronous active-low reset
- enable  in  1  start request; sampled only in S_IDLE
- id  in  32  identifier; bits [ID_LENGTH-1:0] captured at start
- txPulse  in  1  single-cycle bit-start pulse, once per bit period
- samplePulse  in  1  single-cycle sample pulse, three per bit period, all after txPulse
- dIn  in  1  bus readback (0 = dominant, 1 = recessive)
- dOut  out  1  bus drive, registered; 1 = recessive
- idSendComplete  out  1  high once terminal state reached
- arbWon  out  1  all ID_LENGTH bits sent without loss or error
- arbLost  out  1  recessive sent, dominant read back
- bitErr  out  1  dominant sent, recessive read back

## Operation
- Reset values:
  - dOut=1; idSendComplete=0, arbWon=0, arbLost=0, bitErr=0.
  - Shift register = all ones; bitCount=0; sampleCount=0; state S_IDLE.
- S_IDLE: dOut=1. On enable & txPulse, capture id into the shift register, drive bit ID_LENGTH-1, and go to S_SAMPLE.
- S_SAMPLE:
  - Each samplePulse stores dIn in a sample slot and increments sampleCount (0..2).
  - On the third pulse, the majority of the three samples is the read bit, and the state goes to S_CHECK.
- S_CHECK (one cycle):
  - Compare the read bit with the driven bit.
  - dOut=1 and read=0: go to S_LOST.
  - dOut=0 and read=1: go to S_ERROR.
  - Match and bitCount+1==ID_LENGTH: go to S_WON.
  - Otherwise increment bitCount and go to S_WAIT.
- S_WAIT: hold dOut. On txPulse, shift the next bit out on dOut and go to S_SAMPLE.
- S_WON, S_LOST, S_ERROR are terminal and hold until reset. In all three, dOut=1 and idSendComplete=1.
  - S_WON: arbWon=1.
  - S_LOST: arbLost=1.
  - S_ERROR: bitErr=1.
- Status flags are mutually exclusive, and each is only valid while idSendComplete=1.
- Boundary rules:
  - enable is ignored after start. Deasserting it mid-frame has no effect.
  - txPulse is ignored in S_SAMPLE and S_CHECK.
  - samplePulse is ignored in S_IDLE, S_WAIT, S_CHECK and the terminal states.
  - txPulse and samplePulse in the same cycle: only the one legal in the current state acts.
  - Reset asserted mid-frame returns everything to reset values immediately, with dOut=1 asynchronously.

## Timing
- txPulse at cycle T (accepted): dOut carries the new bit from T+1.
- Third samplePulse at cycle S: S_CHECK at S+1; next state (and, for terminal states, the status flags) visible at S+2.
- dOut returns to 1 at S+2 on a loss or error.
- Minimum frame length is ID_LENGTH bit periods. No latency depends on ID value.
- All outputs come from registers or decode of the registered state only. No combinational path from dIn to dOut.

## Structure
- Shared package ch_unit_pkg holds:
  - the txState_t enum (S_IDLE, S_SAMPLE, S_CHECK, S_WAIT, S_WON, S_LOST, S_ERROR), one-hot encoded;
  - constants RECESSIVE=1'b1 and DOMINANT=1'b0;
  - default ID length 11.
- One sub-module, sample_voter: captures three samples on samplePulse, flags the third pulse, and outputs the 2-of-3 majority. It is reusable by the comparator.
- Bit counter width is $clog2(ID_LENGTH+1).

## Test plan
- Clean win: id=0x5A3, bus echoes dOut.
  - Required: dOut bit sequence 1,0,1,1,0,1,0,0,0,1,1.
  - After the 11th check: arbWon=1, idSendComplete=1, dOut=1.
- Arbitration loss: id=0x7FF, bus forced dominant on bit 3 (all three samples).
  - Required: arbLost=1 two cycles after that bit's third samplePulse, dOut=1.
  - No further txPulse changes dOut.
- Bit error: id=0x000, bus forced recessive on bit 0.
  - Required: bitErr=1, arbWon=0, dOut=1.
- Majority vote: id=0x7FF, one of three samples is dominant on one bit.
  - Required: no loss; frame ends with arbWon=1.
  - Two of three dominant: arbLost=1.
- Reset mid-frame plus ignored pulses: reset asserted during bit 5.
  - Required: dOut=1 and all flags 0 asynchronously.
  - With enable=0 after release, txPulse keeps the block in S_IDLE.
  - samplePulse in S_WAIT does not advance sampleCount.
